// File: rtl/pc_gen_unit_if.sv
// Request/response bundle between the pipeline control logic and the PC generator.
// The master raises redirect requests and stalls; the slave returns the fetch PC and status.
interface pc_gen_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            br_valid;
  logic [XLEN-1:0] br_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            mret_valid;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            flush;
  logic            pend_valid;
  logic            misalign;

  modport master (
    output stall, br_valid, br_target, trap_valid, trap_vector, mret_valid, mepc,
    input  pc, pc_plus4, flush, pend_valid, misalign
  );

  modport slave (
    input  stall, br_valid, br_target, trap_valid, trap_vector, mret_valid, mepc,
    output pc, pc_plus4, flush, pend_valid, misalign
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Registered fetch PC with prioritised trap/mret/branch redirect, stall hold and a
// single-entry buffer that keeps a redirect alive while fetch is stalled.
module pc_gen_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              INC      = 4
) (
  input  logic           clk,
  input  logic           rst,
  pc_gen_unit_if.slave   bus
);

  // Ordered so that a numerically larger class always has higher priority.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_MRET = 2'd2,
    SRC_TRAP = 2'd3
  } src_e;

  logic [XLEN-1:0] pc_q;
  logic            flush_q;
  logic            misalign_q;
  logic            pend_q;
  src_e            pend_src_q;
  logic [XLEN-1:0] pend_target_q;

  src_e            live_src;
  logic [XLEN-1:0] live_target;

  always_comb begin
    live_src    = SRC_NONE;
    live_target = '0;
    if (bus.trap_valid) begin
      live_src    = SRC_TRAP;
      live_target = bus.trap_vector;
    end else if (bus.mret_valid) begin
      live_src    = SRC_MRET;
      live_target = bus.mepc;
    end else if (bus.br_valid) begin
      live_src    = SRC_BR;
      live_target = bus.br_target;
    end
    live_target[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      pend_q        <= 1'b0;
      pend_src_q    <= SRC_NONE;
      pend_target_q <= '0;
    end else if (!bus.stall) begin
      pend_q     <= 1'b0;
      pend_src_q <= SRC_NONE;
      if (live_src != SRC_NONE) begin
        pc_q       <= live_target;
        flush_q    <= 1'b1;
        misalign_q <= live_target[1];
      end else if (pend_q) begin
        pc_q       <= pend_target_q;
        flush_q    <= 1'b1;
        misalign_q <= pend_target_q[1];
      end else begin
        pc_q       <= pc_q + XLEN'(INC);
        flush_q    <= 1'b0;
        misalign_q <= 1'b0;
      end
    end else begin
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      // Equal priority replaces so the youngest request of a class wins.
      if (live_src != SRC_NONE && (!pend_q || live_src >= pend_src_q)) begin
        pend_q        <= 1'b1;
        pend_src_q    <= live_src;
        pend_target_q <= live_target;
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_q + XLEN'(INC);
  assign bus.flush      = flush_q;
  assign bus.misalign   = misalign_q;
  assign bus.pend_valid = pend_q;

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Next-generation PC selection stage for the 32-bit RISC-V pipeline. Replaces the 2-way plus4/ALU select with a registered PC that has prioritised multi-source redirect (trap, mret, branch/jump), fetch-stall hold and a one-entry pending-redirect buffer.
- Drives the instruction-fetch address.
- Emits a flush pulse toward IF/ID and ID/EX when a non-sequential target is taken.

Parameters:
- XLEN, 32, PC / target width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- INC, 4, sequential increment added to pc.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  fetch stall; PC must hold.
- br_valid  input  1  branch/jump taken from EX (former PCSel).
- br_target  input  XLEN  branch/jump target from ALU.
- trap_valid  input  1  exception/interrupt entry request.
- trap_vector  input  XLEN  trap handler address (mtvec).
- mret_valid  input  1  return-from-trap request.
- mepc  input  XLEN  return address.
- pc  output  XLEN  current fetch PC (registered).
- pc_plus4  output  XLEN  pc + INC (combinational from pc).
- flush  output  1  registered one-cycle pulse: redirect taken.
- pend_valid  output  1  a redirect is buffered behind a stall.
- misalign  output  1  registered; taken target had bit[1] set.

Behaviour:
- Reset (rst=1 at edge) overrides everything:
  - pc=RESET_PC, flush=0, pend_valid=0, misalign=0.
  - Pending buffer cleared.
  - Reset mid-stall or mid-pending discards the buffered redirect.
- Source priority, highest first: trap_valid > mret_valid > br_valid > pending buffer > sequential (pc+INC).
- Target alignment:
  - Every redirect target has bit[0] forced to 0 before use (JALR rule).
  - If bit[1] of the taken target is 1, misalign=1 for one cycle, coincident with flush. The PC still loads the target; trap raising is the CSR unit's job.
- No stall (stall=0):
  - pc <= highest-priority source.
  - If a live request (trap, mret or br) or the pending buffer was taken: flush=1 next cycle, and the buffer is cleared.
  - Sequential update: flush=0.
- Stall (stall=1):
  - pc holds; flush=0.
  - Any live redirect request is written into the pending buffer (target plus misalign bit); pend_valid=1.
  - A new request while pending replaces the buffer only if its priority is >= the buffered request's priority. Requests of lower priority than the buffered one are dropped.
  - Buffer stores a 2-bit source class (trap/mret/br) for this comparison.
- Stall release:
  - On the first stall=0 cycle, live requests in that cycle beat the buffer per the priority list.
  - The buffer is always cleared on that cycle, whether used or superseded.
- Simultaneous trap and br in the same cycle: trap wins; br is discarded, not buffered.
- Latency:
  - Redirect request to pc update is 1 cycle (stall=0).
  - flush is coincident with the new pc value.
- pc_plus4 wraps modulo 2^XLEN. pc=32'hFFFF_FFFC gives pc_plus4=0; no overflow flag.
- Fetch is assumed to issue exactly one request per cycle when stall=0; there is no additional handshake.

Test Plan:
- Reset then 4 free-running cycles -> pc = 0x0, 0x4, 0x8, 0xC; flush=0 throughout; pc_plus4 = pc+4.
- br_valid=1, br_target=0x0000_0101 at pc=0x10 -> next pc=0x100, flush=1 for exactly one cycle, misalign=0. Repeat with target 0x102 -> pc=0x102, misalign=1.
- Stall 3 cycles with br_valid pulsed (target 0x200) in stall cycle 1:
  - pc holds, pend_valid=1.
  - On release, pc=0x200, flush=1, pend_valid=0.
- During stall, buffer br 0x200, then trap_valid with vector 0x8000_0000:
  - Buffer replaced.
  - On release pc=0x8000_0000.
  - A later br in stall does not replace it.
- Same cycle trap_valid (0x8000_0000), mret_valid (mepc 0x40) and br_valid (0x300), no stall -> pc=0x8000_0000. Next cycle mret alone -> pc=0x40.
- Assert rst while pend_valid=1 -> pc=RESET_PC, pend_valid=0, flush=0. The release after reset proceeds sequentially from RESET_PC.
